// File: rtl/sram_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_resp_pkg
//  Description : Shared definitions for the SRAM responder: read FSM state
//                encodings, counter widths, the idle pin pattern and the
//                saturating-increment helpers.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_resp_pkg;

   // Read FSM state encodings
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_DRIVE = 2'd2;

   // Counter widths
   localparam int CNT_WIDTH      = 32;
   localparam int VIOL_CNT_WIDTH = 16;

   // Registered control pins
   typedef struct packed {
      logic wen;
      logic oen;
      logic cen;
      logic ce2;
   } pins_ctl_t;

   // Deselected, no-access pin pattern that the sample registers reset to
   localparam pins_ctl_t c_idle_pins = '{wen: 1'b1, oen: 1'b1, cen: 1'b1, ce2: 1'b0};

   function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

   function automatic logic [VIOL_CNT_WIDTH-1:0] sat_inc_viol(input logic [VIOL_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + VIOL_CNT_WIDTH'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_resp_mem.sv
`default_nettype none
// ============================================================================
//  Module      : sram_resp_mem
//  Description : Simple dual-port block RAM. One write port, one synchronous
//                read port with 1-cycle latency and read-first behaviour
//                (a same-edge write to the read address returns old data).
//  Ports       : clk           - clock
//                we/waddr/wdata - write port
//                re/raddr      - read request (address sampled on clk)
//                rdata         - registered read data, holds until next re
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_resp_mem #(
   parameter int pDATA_WIDTH     = 8,
   parameter int pMEM_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [pMEM_ADDR_WIDTH-1:0] waddr,
   input  logic [pDATA_WIDTH-1:0]     wdata,
   input  logic                       re,
   input  logic [pMEM_ADDR_WIDTH-1:0] raddr,
   output logic [pDATA_WIDTH-1:0]     rdata
);

   localparam int DEPTH = 1 << pMEM_ADDR_WIDTH;

   logic [pDATA_WIDTH-1:0] mem_q [DEPTH];
   logic [pDATA_WIDTH-1:0] rdata_q;

   // No reset: contents survive reset and map onto block RAM
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_responder
//  Description : Pin-level emulation of an asynchronous 8-bit SRAM. Pins are
//                registered in two stages; writes commit on the rising edge
//                of wen, reads are served by a three-state FSM from block RAM
//                through a registered output driver. Saturating counters
//                report committed writes and completed reads.
//                Optional macro SRAM_RESP_VIOLATION_EN adds protocol
//                violation reporting (violation_count, violation).
//  Ports       : clk, reset_n (async, active low), enable
//                wen/oen/cen (active low), ce2 (active high), addr
//                data        - bidirectional bus, Z unless serving a read
//                write_count - committed writes (saturating)
//                read_count  - completed read drives (saturating)
//                drive       - high while the bus is driven
//                violation_count/violation - only with SRAM_RESP_VIOLATION_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_responder
   import sram_resp_pkg::*;
#(
   parameter int pDATA_WIDTH     = 8,
   parameter int pADDR_WIDTH     = 21,
   parameter int pMEM_ADDR_WIDTH = 10,
   parameter int pREAD_DELAY     = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   wen,
   input  logic                   oen,
   input  logic                   cen,
   input  logic                   ce2,
   input  logic [pADDR_WIDTH-1:0] addr,
   inout  wire  [pDATA_WIDTH-1:0] data,
   output logic [CNT_WIDTH-1:0]   write_count,
   output logic [CNT_WIDTH-1:0]   read_count,
   output logic                   drive
`ifdef SRAM_RESP_VIOLATION_EN
   ,
   output logic [VIOL_CNT_WIDTH-1:0] violation_count,
   output logic                      violation
`endif
);

   localparam int DLY_W = (pREAD_DELAY > 0) ? $clog2(pREAD_DELAY + 1) : 1;
`ifdef SRAM_RESP_VIOLATION_EN
   // Full stage-2 address is needed to spot address changes during writes
   localparam int S2_ADDR_W = pADDR_WIDTH;
`else
   localparam int S2_ADDR_W = pMEM_ADDR_WIDTH;
`endif

   // ---------------------------------------------------------------------
   // Input stage: s1 samples the pins, s2 holds the previous s1 values.
   // oen is not carried into s2 because nothing downstream looks at it.
   // ---------------------------------------------------------------------
   pins_ctl_t              ctl_s1_q, ctl_s1_d;
   logic [pADDR_WIDTH-1:0] addr_s1_q, addr_s1_d;
   logic [pDATA_WIDTH-1:0] data_s1_q, data_s1_d;
   logic                   wen_s2_q, wen_s2_d;
   logic                   cen_s2_q, cen_s2_d;
   logic                   ce2_s2_q, ce2_s2_d;
   logic [S2_ADDR_W-1:0]   addr_s2_q, addr_s2_d;
   logic [pDATA_WIDTH-1:0] data_s2_q, data_s2_d;

   always_comb begin
      ctl_s1_d  = '{wen: wen, oen: oen, cen: cen, ce2: ce2};
      addr_s1_d = addr;
      data_s1_d = data;
      wen_s2_d  = ctl_s1_q.wen;
      cen_s2_d  = ctl_s1_q.cen;
      ce2_s2_d  = ctl_s1_q.ce2;
      addr_s2_d = addr_s1_q[S2_ADDR_W-1:0];
      data_s2_d = data_s1_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctl_s1_q  <= c_idle_pins;
         addr_s1_q <= '0;
         data_s1_q <= '0;
         wen_s2_q  <= c_idle_pins.wen;
         cen_s2_q  <= c_idle_pins.cen;
         ce2_s2_q  <= c_idle_pins.ce2;
         addr_s2_q <= '0;
         data_s2_q <= '0;
      end else begin
         ctl_s1_q  <= ctl_s1_d;
         addr_s1_q <= addr_s1_d;
         data_s1_q <= data_s1_d;
         wen_s2_q  <= wen_s2_d;
         cen_s2_q  <= cen_s2_d;
         ce2_s2_q  <= ce2_s2_d;
         addr_s2_q <= addr_s2_d;
         data_s2_q <= data_s2_d;
      end
   end

   logic sel_s1, sel_s2, rd_cond, wr_commit;

   assign sel_s1    = !ctl_s1_q.cen && ctl_s1_q.ce2 && enable;
   assign sel_s2    = !cen_s2_q && ce2_s2_q && enable;
   assign rd_cond   = sel_s1 && !ctl_s1_q.oen && ctl_s1_q.wen;
   // Write lands on the rising edge of wen using the last low-phase sample
   assign wr_commit = !wen_s2_q && ctl_s1_q.wen && sel_s2;

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic                   ram_re;
   logic [pDATA_WIDTH-1:0] ram_rdata;

   sram_resp_mem #(
      .pDATA_WIDTH     (pDATA_WIDTH),
      .pMEM_ADDR_WIDTH (pMEM_ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (wr_commit),
      .waddr (addr_s2_q[pMEM_ADDR_WIDTH-1:0]),
      .wdata (data_s2_q),
      .re    (ram_re),
      .raddr (addr_s1_q[pMEM_ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   // ---------------------------------------------------------------------
   // Read FSM
   // ---------------------------------------------------------------------
   logic [1:0]             state_q, state_d;
   logic [pADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DLY_W-1:0]       dly_q, dly_d;
   logic                   drive_q, drive_d;
   logic [pDATA_WIDTH-1:0] dout_q, dout_d;
   logic [CNT_WIDTH-1:0]   write_count_q, write_count_d;
   logic [CNT_WIDTH-1:0]   read_count_q, read_count_d;
   logic                   rd_done;

   // State register; drive_q resets asynchronously so the bus lets go at once
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         rd_addr_q     <= '0;
         dly_q         <= '0;
         drive_q       <= 1'b0;
         dout_q        <= '0;
         write_count_q <= '0;
         read_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         dly_q         <= dly_d;
         drive_q       <= drive_d;
         dout_q        <= dout_d;
         write_count_q <= write_count_d;
         read_count_q  <= read_count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      dly_d     = dly_q;
      ram_re    = 1'b0;
      rd_done   = 1'b0;
      // Bus-safety and disable take priority; such an abort is not a
      // completed read and is not counted.
      if (!enable || !ctl_s1_q.wen) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rd_cond) begin
                  ram_re    = 1'b1;
                  rd_addr_d = addr_s1_q;
                  dly_d     = DLY_W'(pREAD_DELAY);
                  state_d   = S_WAIT;
               end
            end
            S_WAIT: begin
               if (!rd_cond) begin
                  state_d = S_IDLE;
               end else if (dly_q == '0) begin
                  state_d = S_DRIVE;
               end else begin
                  dly_d = dly_q - DLY_W'(1);
               end
            end
            S_DRIVE: begin
               if (!rd_cond) begin
                  state_d = S_IDLE;
                  rd_done = 1'b1;
               end else if (addr_s1_q != rd_addr_q) begin
                  ram_re    = 1'b1;
                  rd_addr_d = addr_s1_q;
                  dly_d     = DLY_W'(pREAD_DELAY);
                  state_d   = S_WAIT;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Output logic: the driver engages one edge after S_DRIVE is entered,
   // capturing RAM data into the output register at the same time.
   always_comb begin
      drive_d       = (state_q == S_DRIVE) && (state_d == S_DRIVE);
      dout_d        = drive_d ? ram_rdata : dout_q;
      write_count_d = wr_commit ? sat_inc_cnt(write_count_q) : write_count_q;
      read_count_d  = rd_done   ? sat_inc_cnt(read_count_q)  : read_count_q;
   end

   assign data        = drive_q ? dout_q : {pDATA_WIDTH{1'bz}};
   assign drive       = drive_q;
   assign write_count = write_count_q;
   assign read_count  = read_count_q;

`ifdef SRAM_RESP_VIOLATION_EN
   // ---------------------------------------------------------------------
   // Protocol violations. Level-type faults count once at onset; every
   // address step under a held wen counts separately.
   // ---------------------------------------------------------------------
   logic                      viol_lvl_q, viol_lvl_d;
   logic [VIOL_CNT_WIDTH-1:0] viol_cnt_q, viol_cnt_d;
   logic                      viol_q, viol_d;
   logic                      viol_event;

   always_comb begin
      viol_lvl_d = (enable && !ctl_s1_q.wen && !sel_s1) ||
                   (sel_s1 && !ctl_s1_q.wen && !ctl_s1_q.oen);
      viol_event = (viol_lvl_d && !viol_lvl_q) ||
                   (enable && !ctl_s1_q.wen && !wen_s2_q && (addr_s1_q != addr_s2_q));
      viol_cnt_d = viol_event ? sat_inc_viol(viol_cnt_q) : viol_cnt_q;
      viol_d     = viol_q || viol_event;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         viol_lvl_q <= 1'b0;
         viol_cnt_q <= '0;
         viol_q     <= 1'b0;
      end else begin
         viol_lvl_q <= viol_lvl_d;
         viol_cnt_q <= viol_cnt_d;
         viol_q     <= viol_d;
      end
   end

   assign violation_count = viol_cnt_q;
   assign violation       = viol_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_responder
//  Description : Self-checking bench for sram_responder. Stimulus tasks push
//                expected read data and arrival cycle into a scoreboard; a
//                negedge monitor pops and compares each time the DUT starts
//                driving. Counters are checked against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_responder;

   localparam int AW = 21;
   localparam int DW = 8;
   localparam int MW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          enable = 1'b1;
   logic          wen = 1'b1;
   logic          oen = 1'b1;
   logic          cen = 1'b1;
   logic          ce2 = 1'b0;
   logic [AW-1:0] addr = '0;
   wire  [DW-1:0] data;
   logic [DW-1:0] tb_drv = '0;
   logic          tb_oe = 1'b0;
   logic [31:0]   write_count;
   logic [31:0]   read_count;
   logic          drive;
`ifdef SRAM_RESP_VIOLATION_EN
   logic [15:0]   violation_count;
   logic          violation;
`endif

   assign data = tb_oe ? tb_drv : {DW{1'bz}};

   sram_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .wen         (wen),
      .oen         (oen),
      .cen         (cen),
      .ce2         (ce2),
      .addr        (addr),
      .data        (data),
      .write_count (write_count),
      .read_count  (read_count),
      .drive       (drive)
`ifdef SRAM_RESP_VIOLATION_EN
      ,
      .violation_count (violation_count),
      .violation       (violation)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model
   logic [DW-1:0] mdl_mem [1 << MW];
   int unsigned   exp_writes = 0;
   int unsigned   exp_reads  = 0;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } exp_t;
   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   // Monitor: every new bus drive must match the oldest expectation,
   // both in value and in the cycle it appears.
   logic drive_prev = 1'b0;
   always @(negedge clk) begin
      if (reset_n && drive && !drive_prev) begin
         checks <= checks + 1;
         if (sb_q.size() == 0) begin
            failures <= failures + 1;
            $display("FAIL unexpected_drive data=%h cyc=%0d expected=no drive", data, cyc);
         end else begin
            if (data !== sb_q[0].d || cyc != sb_q[0].c) begin
               failures <= failures + 1;
               $display("FAIL read_data got=%h@cyc%0d expected=%h@cyc%0d",
                        data, cyc, sb_q[0].d, sb_q[0].c);
            end
            void'(sb_q.pop_front());
         end
      end
      drive_prev <= drive;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 30) begin
         tick(1);
         n++;
      end
      chk("sb_drain_pending", sb_q.size(), 0);
      sb_q.delete();
   endtask

   // wen low for len+1 cycles; the bench drives data from the second cycle
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int len, input bit desel);
      addr = a;
      wen  = 1'b0;
      if (desel) begin
         if ($urandom_range(0, 1) == 0) begin
            cen = 1'b1; ce2 = 1'b1;
         end else begin
            cen = 1'b0; ce2 = 1'b0;
         end
      end else begin
         cen = 1'b0; ce2 = 1'b1;
      end
      tick(1);
      tb_drv = d;
      tb_oe  = 1'b1;
      tick(len);
      wen   = 1'b1;
      tb_oe = 1'b0;
      cen   = 1'b0;
      ce2   = 1'b1;
      if (!desel) begin
         mdl_mem[a[MW-1:0]] = d;
         exp_writes++;
      end
      tick(3);
      chk("write_count", write_count, exp_writes);
   endtask

   // Read held for hold cycles; optionally step to a2 and hold again
   task automatic do_read(input logic [AW-1:0] a, input int hold,
                          input bit change, input logic [AW-1:0] a2);
      addr = a;
      cen  = 1'b0;
      ce2  = 1'b1;
      oen  = 1'b0;
      sb_q.push_back('{d: mdl_mem[a[MW-1:0]], c: cyc + 4});
      tick(hold);
      if (change) begin
         addr = a2;
         sb_q.push_back('{d: mdl_mem[a2[MW-1:0]], c: cyc + 4});
         tick(hold);
      end
      oen = 1'b1;
      exp_reads++;
      tick(3);
      chk("read_count", read_count, exp_reads);
      chk("drive_released", drive, 1'b0);
      wait_drain();
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = AW'($urandom());
      a[MW-1:0] = MW'($urandom_range(0, 15));
      return a;
   endfunction

   initial begin
      logic [AW-1:0] a, a2;
      int            op;

      // Reset state
      tick(3);
      chk("reset_drive", drive, 1'b0);
      chk("reset_write_count", write_count, 0);
      chk("reset_read_count", read_count, 0);
      #2 reset_n = 1'b1;
      tick(2);

      // Write then read
      do_write(21'h000003, 8'hA5, 1, 1'b0);
      do_read(21'h000003, 6, 1'b0, '0);

      // Aliasing of upper address bits
      do_write(21'h000400, 8'h3C, 1, 1'b0);
      do_read(21'h000000, 5, 1'b0, '0);

      // Deselected write is dropped
      do_write(21'h000005, 8'h11, 2, 1'b0);
      do_write(21'h000005, 8'hFF, 1, 1'b1);
      do_read(21'h000005, 5, 1'b0, '0);
`ifdef SRAM_RESP_VIOLATION_EN
      chk("violation_count", violation_count, 1);
      chk("violation", violation, 1'b1);
`endif

      // Address change while reading
      do_write(21'h000001, 8'h5A, 1, 1'b0);
      do_write(21'h000002, 8'hC3, 1, 1'b0);
      do_read(21'h000001, 6, 1'b1, 21'h000002);

      // Contention: wen asserted during a drive
      addr = 21'h000001;
      oen  = 1'b0;
      sb_q.push_back('{d: mdl_mem[1], c: cyc + 4});
      tick(6);
      wen = 1'b0;
      tick(2);
      chk("contention_release", drive, 1'b0);
      tb_drv = 8'h77;
      tb_oe  = 1'b1;
      tick(1);
      wen   = 1'b1;
      oen   = 1'b1;
      tb_oe = 1'b0;
      mdl_mem[1] = 8'h77;
      exp_writes++;
      tick(3);
      chk("contention_write_count", write_count, exp_writes);
      chk("contention_read_count", read_count, exp_reads);
      wait_drain();
      do_read(21'h000001, 5, 1'b0, '0);

      // enable=0 releases the bus without counting the read
      addr = 21'h000002;
      oen  = 1'b0;
      sb_q.push_back('{d: mdl_mem[2], c: cyc + 4});
      tick(5);
      enable = 1'b0;
      tick(2);
      chk("disable_release", drive, 1'b0);
      oen = 1'b1;
      tick(2);
      enable = 1'b1;
      tick(2);
      chk("disable_read_count", read_count, exp_reads);
      wait_drain();

      // Reset mid-read: asynchronous release, counters cleared, memory kept
      addr = 21'h000003;
      oen  = 1'b0;
      sb_q.push_back('{d: mdl_mem[3], c: cyc + 4});
      tick(5);
      wait_drain();
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_drive", drive, 1'b0);
      chk("async_reset_write_count", write_count, 0);
      chk("async_reset_read_count", read_count, 0);
      exp_writes = 0;
      exp_reads  = 0;
      oen = 1'b1;
      #3 reset_n = 1'b1;
      tick(2);
      do_read(21'h000003, 5, 1'b0, '0);

      // Randomized traffic over a small address pool
      for (int i = 0; i < 16; i++) begin
         a = rand_addr();
         a[MW-1:0] = MW'(i);
         do_write(a, DW'($urandom()), $urandom_range(1, 3), 1'b0);
      end
      for (int i = 0; i < 50; i++) begin
         op = $urandom_range(0, 9);
         if (op < 4) begin
            do_write(rand_addr(), DW'($urandom()), $urandom_range(1, 3),
                     ($urandom_range(0, 4) == 0));
         end else if (op < 8) begin
            a  = rand_addr();
            a2 = rand_addr();
            if (a2 == a) a2[AW-1] = ~a2[AW-1];
            do_read(a, $urandom_range(5, 8), ($urandom_range(0, 2) == 0), a2);
         end else begin
            tick($urandom_range(1, 4));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout cyc=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable responder that emulates an asynchronous-style 8-bit SRAM at the pin level: write enable, output enable, chip enables, address and a bidirectional data bus.
- Stores writes in an internal block RAM and drives read data back onto the shared bus.
- Sits opposite the SRAM test initiator, so board-test pattern logic can be closed-loop checked in simulation and on an FPGA with no external SRAM fitted.
- Also provides saturating access counters for the board-test status registers.

Parameters:
- pDATA_WIDTH, 8, data bus width in bits.
- pADDR_WIDTH, 21, width of the external address port.
- pMEM_ADDR_WIDTH, 10, number of address LSBs actually stored (depth 2^pMEM_ADDR_WIDTH). Upper address bits are ignored, so addresses alias.
- pREAD_DELAY, 0, extra clk cycles inserted before read data is driven.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 0, ignore all pin activity and keep data tristated.
- wen  in  1  write enable, active low.
- oen  in  1  output enable, active low.
- cen  in  1  chip enable, active low.
- ce2  in  1  chip enable, active high.
- addr  in  pADDR_WIDTH  address.
- data  inout  pDATA_WIDTH  bidirectional data bus; high-Z unless driving read data.
- write_count  out  32  number of committed writes, saturating.
- read_count  out  32  number of completed read drives, saturating.
- drive  out  1  high while data is being driven; observation only.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - write_count=0, read_count=0, drive=0, data=Z, state=S_IDLE.
  - All pin-sample registers clear to the idle pattern: wen=1, oen=1, cen=1, ce2=0.
  - Memory contents are not reset.
- Input stage: wen, oen, cen, ce2, addr and data are registered every clk (stage s1). The previous s1 values are held in stage s2.
- sel = (s1.cen==0) && (s1.ce2==1) && enable.
- Write commit:
  - Condition: s2.wen==0, s1.wen==1 (rising edge of wen) and s2-stage sel true.
  - Writes s2.data to mem[s2.addr[pMEM_ADDR_WIDTH-1:0]].
  - write_count increments on the same edge.
  - A wen low pulse with chip deselected is dropped and not counted.
- Read FSM states:
  - S_IDLE: data=Z. If sel && s1.oen==0 && s1.wen==1, issue a RAM read of s1.addr, latch that address into rd_addr, load a delay counter with pREAD_DELAY, and go to S_WAIT.
  - S_WAIT: wait one cycle for RAM data plus pREAD_DELAY cycles, then go to S_DRIVE with data driven from the output register.
  - S_DRIVE: drive=1, data=rd_data. Stay while the read condition holds and s1.addr==rd_addr. On an address change with the read condition still true, go to S_WAIT and re-read. When the condition drops, go to S_IDLE, release the bus and increment read_count once.
- Read latency: data is driven exactly 3+pREAD_DELAY clk edges after the edge at which the read condition is first present on the pins.
- Drive release: the bus is released 1 edge after the condition drops (registered pins plus a registered output-enable).
- Bus-safety rule: if s1.wen==0 in any state, force the FSM to S_IDLE and data=Z on that edge, before any other action.
- Simultaneous write commit and read issue to the same address: the RAM is read-first, so old data is returned; the initiator's protocol never does this.
- Counters: at 32'hFFFF_FFFF they hold.
- enable=0: go to S_IDLE and release the bus. Counters hold. Memory is retained.
- reset_n asserted mid-transfer: the bus is released immediately (asynchronous path to the output enable).

Optional Feature:
- Macro SRAM_RESP_VIOLATION_EN.
- When defined:
  - Adds output violation_count (16-bit, saturating, reset 0).
  - Adds sticky output violation (reset 0; cleared only by reset).
  - Both increment/set on any of the following:
    - wen low while chip deselected;
    - oen and wen both low with chip selected;
    - addr changing while wen is low.
- When undefined: these ports and their logic are absent, and all other behaviour is identical.

Decomposition:
- Package sram_resp_pkg:
  - state localparams S_IDLE/S_WAIT/S_DRIVE (2-bit);
  - counter widths 32 and 16;
  - the idle pin pattern constant.
- One sub-module, sram_resp_mem: simple dual-port BRAM with a synchronous, read-first read port and 1-cycle latency, parameterized by pDATA_WIDTH and pMEM_ADDR_WIDTH.

Test Plan:
- Write then read: write 8'hA5 to addr 0x000003 with cen=0, ce2=1 and a 2-cycle wen pulse; then read with oen=0. Expect data=8'hA5 on the 3rd edge, write_count=1, and read_count=1 after oen rises.
- Aliasing: write 8'h3C to addr 0x000400 (pMEM_ADDR_WIDTH=10), then read addr 0x000000. Expect 8'h3C.
- Deselected write: wen pulse with cen=1, ce2=0 carrying 8'hFF to addr 5. Expect write_count unchanged and the prior contents of addr 5 unchanged. With SRAM_RESP_VIOLATION_EN: violation_count=1, violation=1.
- Address change while reading: hold oen=0 and step addr 1→2 during S_DRIVE. Expect the bus to show mem[2] 3 edges after the change, and read_count to increment only once, at oen release.
- Contention: assert wen=0 during S_DRIVE. Expect data=Z on the next edge and the FSM in S_IDLE.
- Reset mid-read: pull reset_n low asynchronously during S_DRIVE. Expect data=Z and drive=0 without waiting for a clk edge, and both counters=0.
